// File: rtl/omsp_result_fifo.sv
// Result-capture peripheral for the openMSP430 peripheral bus.
// CPU writes to the DATA register push 16-bit words into a FIFO. A consumer
// drains the FIFO through a valid/ready stream. Accepting a zero word raises a
// sticky done flag. While done is set, further pushes are ignored.
module omsp_result_fifo #(
  parameter logic [13:0] BASE_ADDR = 14'h0080,
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  output logic [15:0] per_dout,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic        overflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic          sel;
  logic [1:0]    off;
  logic          is_wr;
  logic          push_req;
  logic          clr;
  logic          pop;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          push_drop;
  logic [15:0]   push_word;
  logic [7:0]    count8;
  logic [15:0]   status;

  // Bus decode and push/pop arbitration
  always_comb begin
    sel       = per_en && (per_addr[13:2] == BASE_ADDR[13:2]);
    off       = per_addr[1:0];
    is_wr     = |per_we;
    push_req  = sel && is_wr && (off == 2'd0);
    clr       = sel && per_we[0] && per_din[0] && (off == 2'd2);
    push_word = {per_we[1] ? per_din[15:8] : 8'h00,
                 per_we[0] ? per_din[7:0]  : 8'h00};
    empty     = (count == '0);
    full      = (count == DEPTH_C);
    pop       = !empty && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    push_ok   = push_req && !done && (!full || pop);
    push_drop = push_req && !done && full && !pop;
  end

  // Storage array; contents are not reset, only the pointers are
  always_ff @(posedge mclk) begin
    if (push_ok) mem[wptr] <= push_word;
  end

  // Pointers, occupancy and sticky flags; clear overrides any same-cycle pop
  always_ff @(posedge mclk) begin
    if (puc_rst || clr) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push_ok && (push_word == 16'h0000)) done <= 1'b1;
      if (push_drop) overflow <= 1'b1;
    end
  end

  // Status word and read mux; per_dout stays 0 unless STATUS is being read
  always_comb begin
    count8          = '0;
    count8[AW:0]    = count;
    status          = {count8, 4'b0000, done, overflow, full, empty};
    per_dout        = 16'h0000;
    if (sel && !is_wr && (off == 2'd1)) per_dout = status;
  end

  // Stream output taken directly from the registered storage
  always_comb begin
    out_valid = !empty;
    out_data  = mem[rptr];
  end

endmodule

// File: tb/tb_omsp_result_fifo.sv
// Scoreboard bench for omsp_result_fifo (DEPTH=16, base word address 0x0080).
module tb_omsp_result_fifo;

  logic        mclk;
  logic        puc_rst;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        overflow;

  localparam logic [13:0] A_DATA = 14'h0080;
  localparam logic [13:0] A_STAT = 14'h0081;
  localparam logic [13:0] A_CTRL = 14'h0082;
  localparam logic [13:0] A_RSV  = 14'h0083;
  localparam logic [13:0] A_FAR  = 14'h0090;

  logic [15:0] exp_q[$];
  logic        m_done;
  logic        m_ovf;
  logic [15:0] last_dout;
  int          n_checks;
  int          n_fail;

  omsp_result_fifo #(
    .BASE_ADDR(14'h0080),
    .DEPTH(16),
    .AW(4)
  ) dut (
    .mclk(mclk),
    .puc_rst(puc_rst),
    .per_en(per_en),
    .per_we(per_we),
    .per_addr(per_addr),
    .per_din(per_din),
    .per_dout(per_dout),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done(done),
    .overflow(overflow)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, compare at the falling edge, advance the model.
  task automatic cycle(input logic en, input logic [1:0] we, input logic [13:0] addr,
                       input logic [15:0] din);
    logic        sel;
    logic        pop;
    logic        acc;
    logic [15:0] w;
    logic [15:0] exp_dout;
    logic [7:0]  n8;
    int          n;
    per_en = en; per_we = we; per_addr = addr; per_din = din;
    @(negedge mclk);
    n  = exp_q.size();
    n8 = 8'(n);
    check("out_valid", {15'b0, out_valid}, {15'b0, n != 0});
    check("done",      {15'b0, done},      {15'b0, m_done});
    check("overflow",  {15'b0, overflow},  {15'b0, m_ovf});
    pop = (n != 0) && out_ready;
    if (pop) check("out_data", out_data, exp_q[0]);
    sel = en && (addr[13:2] == 12'h020);
    exp_dout = 16'h0000;
    if (sel && we == 2'b00 && addr[1:0] == 2'd1)
      exp_dout = {n8, 4'b0000, m_done, m_ovf, n == 16, n == 0};
    check("per_dout", per_dout, exp_dout);
    last_dout = per_dout;
    if (sel && we[0] && addr[1:0] == 2'd2 && din[0]) begin
      exp_q.delete();
      m_done = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      acc = 1'b0;
      w   = {we[1] ? din[15:8] : 8'h00, we[0] ? din[7:0] : 8'h00};
      if (sel && we != 2'b00 && addr[1:0] == 2'd0 && !m_done) begin
        if (n < 16 || pop) acc = 1'b1;
        else m_ovf = 1'b1;
      end
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(w);
        if (w == 16'h0000) m_done = 1'b1;
      end
    end
    @(posedge mclk);
    #1;
    per_en = 1'b0;
    per_we = 2'b00;
  endtask

  task automatic do_reset();
    puc_rst = 1'b1;
    @(posedge mclk);
    @(posedge mclk);
    #1;
    puc_rst = 1'b0;
    exp_q.delete();
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 14'h0000, 16'h0000);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    per_en = 0; per_we = 0; per_addr = 0; per_din = 0; out_ready = 0;
    m_done = 0; m_ovf = 0; last_dout = 0;
    do_reset();

    // Reset state
    idle(1);
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_reset", last_dout, 16'h0001);

    // Two pushes held, then drained back to back
    cycle(1'b1, 2'b11, A_DATA, 16'h1234);
    cycle(1'b1, 2'b11, A_DATA, 16'hBEEF);
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_two", last_dout, 16'h0200);
    out_ready = 1'b1;
    idle(3);
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_drained", last_dout, 16'h0001);

    // Byte-lane writes
    cycle(1'b1, 2'b01, A_DATA, 16'hAB55);
    cycle(1'b1, 2'b10, A_DATA, 16'hAB55);
    idle(2);

    // Other offsets and foreign addresses
    cycle(1'b1, 2'b00, A_DATA, 16'h0);
    cycle(1'b1, 2'b00, A_CTRL, 16'h0);
    cycle(1'b1, 2'b00, A_RSV,  16'h0);
    cycle(1'b1, 2'b11, A_STAT, 16'h0000);
    cycle(1'b1, 2'b11, A_RSV,  16'h0000);
    cycle(1'b1, 2'b11, A_FAR,  16'h0000);
    cycle(1'b1, 2'b00, A_FAR + 14'h1, 16'h0);
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_ignored", last_dout, 16'h0001);

    // Overflow: 17 pushes into 16 entries, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) cycle(1'b1, 2'b11, A_DATA, 16'h1000 + 16'(i));
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_full_ovf", last_dout, 16'h1006);
    out_ready = 1'b1;
    idle(17);
    cycle(1'b1, 2'b01, A_CTRL, 16'h0001);
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_cleared", last_dout, 16'h0001);

    // Full FIFO with a same-cycle pop accepts the push
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) cycle(1'b1, 2'b11, A_DATA, 16'h2000 + 16'(i));
    out_ready = 1'b1;
    cycle(1'b1, 2'b11, A_DATA, 16'h2FFF);
    out_ready = 1'b0;
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_full_pop", last_dout, 16'h1002);
    out_ready = 1'b1;
    idle(17);

    // Clear wins over a same-cycle pop
    out_ready = 1'b0;
    cycle(1'b1, 2'b11, A_DATA, 16'h0A0A);
    cycle(1'b1, 2'b11, A_DATA, 16'h0B0B);
    out_ready = 1'b1;
    cycle(1'b1, 2'b11, A_CTRL, 16'h0001);
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_clr_pop", last_dout, 16'h0001);

    // Done: 5, 0 stored, 7 ignored
    out_ready = 1'b0;
    cycle(1'b1, 2'b11, A_DATA, 16'h0005);
    cycle(1'b1, 2'b11, A_DATA, 16'h0000);
    cycle(1'b1, 2'b11, A_DATA, 16'h0007);
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_done", last_dout, 16'h0208);
    out_ready = 1'b1;
    idle(3);
    cycle(1'b1, 2'b01, A_CTRL, 16'h0001);
    cycle(1'b1, 2'b00, A_STAT, 16'h0);
    check("stat_done_clr", last_dout, 16'h0001);

    // Reset mid-drain discards contents
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'b11, A_DATA, 16'h3000 + 16'(i));
    out_ready = 1'b1;
    idle(1);
    do_reset();
    idle(1);

    // Random traffic with nonzero words
    for (int i = 0; i < 80; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       idle(1);
        3:       cycle(1'b1, 2'b00, A_STAT, 16'h0);
        default: cycle(1'b1, 2'b11, A_DATA, 16'($urandom) | 16'h0001);
      endcase
    end
    out_ready = 1'b1;
    idle(18);
    cycle(1'b1, 2'b00, A_STAT, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
